z80_bus_arbiter: RTL and testbench

Z80_BUS_ARBITER -- requirements
Module: z80_bus_arbiter

---
 rtl/z80_bus_arbiter.sv | 164 ++++++++++++++++
 tb/tb_z80_bus_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/z80_bus_arbiter.sv
// Z80 bus arbiter: shares the CPU bus with a secondary DMA master and inserts memory wait states.
// Optional DMA hold timeout is enabled by defining ARB_TIMEOUT_EN.
module z80_bus_arbiter #(
    parameter int WAIT_STATES    = 2,
    parameter int MIN_CPU_CYCLES = 16,
    parameter int DMA_TIMEOUT    = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic mreq_n,
    input  logic busak_n,
    output logic busrq_n,
    output logic wait_n,
    input  logic dma_req,
    output logic dma_gnt,
    output logic bus_sel,
    output logic timeout_flag
);

    if (WAIT_STATES < 0 || WAIT_STATES > 15 || MIN_CPU_CYCLES < 1 ||
        MIN_CPU_CYCLES > 255 || DMA_TIMEOUT < 1) begin : g_param_check
        $error("z80_bus_arbiter: parameter out of range");
    end

    localparam logic [3:0] WAIT_C = 4'(WAIT_STATES);
    localparam logic [7:0] MIN_C  = 8'(MIN_CPU_CYCLES);

    typedef enum logic [1:0] {
        CPU_OWN = 2'd0,
        REQ_BUS = 2'd1,
        DMA_OWN = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t     state_q;
    logic [7:0] fair_q;
    logic [3:0] wait_cnt_q;
    logic       mreq_prev_q;
    logic       busrq_n_q;
    logic       wait_n_q;
    logic       dma_gnt_q;
    logic       bus_sel_q;

    logic       mreq_fall;
    logic       tmo_block;
    logic       dma_go;

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(DMA_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(DMA_TIMEOUT - 1);

    logic [TW-1:0] tmo_q;
    logic          tmo_flag_q;
    logic          tmo_block_q;

    assign timeout_flag = tmo_flag_q;
    assign tmo_block    = tmo_block_q;
`else
    assign timeout_flag = 1'b0;
    assign tmo_block    = 1'b0;
`endif

    // A fresh memory cycle starting this clock wins over a pending DMA request.
    always_comb begin
        mreq_fall = mreq_prev_q & ~mreq_n;
        dma_go    = dma_req & (fair_q >= MIN_C) & (wait_cnt_q == 4'd0) &
                    ~(mreq_fall & (WAIT_C != 4'd0)) & ~tmo_block;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= CPU_OWN;
            fair_q      <= 8'd0;
            wait_cnt_q  <= 4'd0;
            mreq_prev_q <= 1'b1;
            busrq_n_q   <= 1'b1;
            wait_n_q    <= 1'b1;
            dma_gnt_q   <= 1'b0;
            bus_sel_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            tmo_q       <= '0;
            tmo_flag_q  <= 1'b0;
            tmo_block_q <= 1'b0;
`endif
        end else begin
            mreq_prev_q <= mreq_n;
`ifdef ARB_TIMEOUT_EN
            if (!dma_req) begin
                tmo_block_q <= 1'b0;
            end
`endif
            case (state_q)
                CPU_OWN: begin
                    if (fair_q < MIN_C) begin
                        fair_q <= fair_q + 8'd1;
                    end
                    if (wait_cnt_q != 4'd0) begin
                        if (mreq_n) begin
                            wait_cnt_q <= 4'd0;
                            wait_n_q   <= 1'b1;
                        end else begin
                            wait_cnt_q <= wait_cnt_q - 4'd1;
                            wait_n_q   <= (wait_cnt_q == 4'd1);
                        end
                    end else if (mreq_fall && (WAIT_C != 4'd0)) begin
                        wait_cnt_q <= WAIT_C;
                        wait_n_q   <= 1'b0;
                    end else if (dma_go) begin
                        state_q   <= REQ_BUS;
                        busrq_n_q <= 1'b0;
                    end
                end
                REQ_BUS: begin
                    if (!dma_req) begin
                        state_q   <= RELEASE;
                        busrq_n_q <= 1'b1;
                    end else if (!busak_n) begin
                        state_q   <= DMA_OWN;
                        dma_gnt_q <= 1'b1;
                        bus_sel_q <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        tmo_q     <= '0;
`endif
                    end
                end
                DMA_OWN: begin
                    if (!dma_req) begin
                        state_q   <= RELEASE;
                        busrq_n_q <= 1'b1;
                        dma_gnt_q <= 1'b0;
                        bus_sel_q <= 1'b0;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (tmo_q == TMO_LAST) begin
                        state_q     <= RELEASE;
                        busrq_n_q   <= 1'b1;
                        dma_gnt_q   <= 1'b0;
                        bus_sel_q   <= 1'b0;
                        tmo_flag_q  <= 1'b1;
                        tmo_block_q <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
`endif
                end
                RELEASE: begin
                    if (busak_n) begin
                        state_q <= CPU_OWN;
                        fair_q  <= 8'd0;
                    end
                end
                default: begin
                    state_q <= CPU_OWN;
                end
            endcase
        end
    end

    assign busrq_n = busrq_n_q;
    assign wait_n  = wait_n_q;
    assign dma_gnt = dma_gnt_q;
    assign bus_sel = bus_sel_q;

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// Directed self-checking bench for z80_bus_arbiter (default build and ARB_TIMEOUT_EN build).
module tb_z80_bus_arbiter;

    logic clk;
    logic reset_n;
    logic mreq_n, busak_n, dma_req;
    logic busrq_n, wait_n, dma_gnt, bus_sel, timeout_flag;
    logic m4_mreq_n, m4_dma_req;
    logic m4_busrq_n, m4_wait_n, m4_dma_gnt, m4_bus_sel, m4_timeout_flag;

    int errors = 0;
    int checks = 0;

    z80_bus_arbiter #(.WAIT_STATES(2), .MIN_CPU_CYCLES(16), .DMA_TIMEOUT(8)) u_dut (
        .clk(clk), .reset_n(reset_n), .mreq_n(mreq_n), .busak_n(busak_n),
        .busrq_n(busrq_n), .wait_n(wait_n), .dma_req(dma_req),
        .dma_gnt(dma_gnt), .bus_sel(bus_sel), .timeout_flag(timeout_flag)
    );

    z80_bus_arbiter #(.WAIT_STATES(4), .MIN_CPU_CYCLES(16), .DMA_TIMEOUT(8)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .mreq_n(m4_mreq_n), .busak_n(1'b1),
        .busrq_n(m4_busrq_n), .wait_n(m4_wait_n), .dma_req(m4_dma_req),
        .dma_gnt(m4_dma_gnt), .bus_sel(m4_bus_sel), .timeout_flag(m4_timeout_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b1; mreq_n = 1'b1; busak_n = 1'b1; dma_req = 1'b0;
        m4_mreq_n = 1'b1; m4_dma_req = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checks++; if (busrq_n !== 1'b1) begin errors++; $display("FAIL reset_busrq_n got=%b exp=1", busrq_n); end
        checks++; if (wait_n !== 1'b1) begin errors++; $display("FAIL reset_wait_n got=%b exp=1", wait_n); end
        checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL reset_dma_gnt got=%b exp=0", dma_gnt); end
        checks++; if (bus_sel !== 1'b0) begin errors++; $display("FAIL reset_bus_sel got=%b exp=0", bus_sel); end
        checks++; if (timeout_flag !== 1'b0) begin errors++; $display("FAIL reset_timeout_flag got=%b exp=0", timeout_flag); end
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // dma_req raised on cycle 20; busak_n answers two cycles after busrq_n falls
    task automatic test_dma_grant();
        repeat (19) tick();
        dma_req = 1'b1;
        tick();
        checks++; if (busrq_n !== 1'b0) begin errors++; $display("FAIL grant_busrq_n got=%b exp=0", busrq_n); end
        checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL grant_early_gnt got=%b exp=0", dma_gnt); end
        tick();
        checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL grant_wait_ack_gnt got=%b exp=0", dma_gnt); end
        busak_n = 1'b0;
        tick();
        checks++; if (dma_gnt !== 1'b1) begin errors++; $display("FAIL grant_dma_gnt got=%b exp=1", dma_gnt); end
        checks++; if (bus_sel !== 1'b1) begin errors++; $display("FAIL grant_bus_sel got=%b exp=1", bus_sel); end
        checks++; if (busrq_n !== 1'b0) begin errors++; $display("FAIL grant_busrq_held got=%b exp=0", busrq_n); end
        checks++; if (wait_n !== 1'b1) begin errors++; $display("FAIL grant_wait_n got=%b exp=1", wait_n); end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_dma_hold();
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (dma_gnt !== ((i < 8) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL timeout_gnt cycle=%0d got=%b exp=%b", i, dma_gnt, (i < 8));
            end
        end
        checks++; if (timeout_flag !== 1'b1) begin errors++; $display("FAIL timeout_flag got=%b exp=1", timeout_flag); end
        checks++; if (busrq_n !== 1'b1) begin errors++; $display("FAIL timeout_busrq_n got=%b exp=1", busrq_n); end
        busak_n = 1'b1;
        repeat (20) tick();
        checks++; if (busrq_n !== 1'b1) begin errors++; $display("FAIL timeout_no_regrant got=%b exp=1", busrq_n); end
        dma_req = 1'b0;
        tick();
        dma_req = 1'b1;
        tick();
        checks++; if (busrq_n !== 1'b0) begin errors++; $display("FAIL timeout_regrant got=%b exp=0", busrq_n); end
        checks++; if (timeout_flag !== 1'b1) begin errors++; $display("FAIL timeout_sticky got=%b exp=1", timeout_flag); end
        busak_n = 1'b0;
        tick();
        checks++; if (dma_gnt !== 1'b1) begin errors++; $display("FAIL timeout_regrant_gnt got=%b exp=1", dma_gnt); end
    endtask
`else
    task automatic test_dma_hold();
        repeat (20) tick();
        checks++; if (dma_gnt !== 1'b1) begin errors++; $display("FAIL hold_dma_gnt got=%b exp=1", dma_gnt); end
        checks++; if (timeout_flag !== 1'b0) begin errors++; $display("FAIL hold_timeout_flag got=%b exp=0", timeout_flag); end
    endtask
`endif

    task automatic test_release();
        tick();
        tick();
        checks++; if (dma_gnt !== 1'b1) begin errors++; $display("FAIL release_pre_gnt got=%b exp=1", dma_gnt); end
        dma_req = 1'b0;
        tick();
        checks++; if (busrq_n !== 1'b1) begin errors++; $display("FAIL release_busrq_n got=%b exp=1", busrq_n); end
        checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL release_dma_gnt got=%b exp=0", dma_gnt); end
        checks++; if (bus_sel !== 1'b0) begin errors++; $display("FAIL release_bus_sel got=%b exp=0", bus_sel); end
        tick();
        tick();
        busak_n = 1'b1;
        tick();
        dma_req = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            checks++;
            if (busrq_n !== 1'b1) begin errors++; $display("FAIL fairness_hold cycle=%0d got=%b exp=1", i, busrq_n); end
        end
        tick();
        checks++; if (busrq_n !== 1'b0) begin errors++; $display("FAIL fairness_request got=%b exp=0", busrq_n); end
        // requester gives up before the CPU acknowledges
        dma_req = 1'b0;
        tick();
        checks++; if (busrq_n !== 1'b1) begin errors++; $display("FAIL abort_busrq_n got=%b exp=1", busrq_n); end
        checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL abort_dma_gnt got=%b exp=0", dma_gnt); end
        tick();
    endtask

    task automatic test_wait();
        logic exp_w [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        mreq_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (wait_n !== exp_w[i]) begin errors++; $display("FAIL wait2 cycle=%0d got=%b exp=%b", i, wait_n, exp_w[i]); end
        end
        mreq_n = 1'b1;
        tick();
        mreq_n = 1'b0;
        tick();
        checks++; if (wait_n !== 1'b0) begin errors++; $display("FAIL wait_abort_start got=%b exp=0", wait_n); end
        mreq_n = 1'b1;
        tick();
        checks++; if (wait_n !== 1'b1) begin errors++; $display("FAIL wait_abort_clear got=%b exp=1", wait_n); end
        tick();
        checks++; if (wait_n !== 1'b1) begin errors++; $display("FAIL wait_abort_stay got=%b exp=1", wait_n); end
    endtask

    // memory cycle and DMA request start together: the wait count goes first
    task automatic test_wait_defers_dma();
        logic exp_rq [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic exp_w  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        repeat (17) tick();
        mreq_n  = 1'b0;
        dma_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (busrq_n !== exp_rq[i]) begin errors++; $display("FAIL defer_busrq_n cycle=%0d got=%b exp=%b", i, busrq_n, exp_rq[i]); end
            checks++;
            if (wait_n !== exp_w[i]) begin errors++; $display("FAIL defer_wait_n cycle=%0d got=%b exp=%b", i, wait_n, exp_w[i]); end
        end
        dma_req = 1'b0;
        mreq_n  = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_wait4_defers_dma();
        logic exp_rq [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        m4_mreq_n = 1'b0;
        tick();
        checks++; if (m4_wait_n !== 1'b0) begin errors++; $display("FAIL wait4_start got=%b exp=0", m4_wait_n); end
        tick();
        m4_dma_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (m4_busrq_n !== exp_rq[i]) begin errors++; $display("FAIL wait4_busrq_n cycle=%0d got=%b exp=%b", i, m4_busrq_n, exp_rq[i]); end
            if (i == 2) begin
                checks++;
                if (m4_wait_n !== 1'b1) begin errors++; $display("FAIL wait4_expire got=%b exp=1", m4_wait_n); end
            end
        end
        m4_dma_req = 1'b0;
        m4_mreq_n  = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_async_reset();
        dma_req = 1'b1;
        repeat (17) tick();
        checks++; if (busrq_n !== 1'b0) begin errors++; $display("FAIL areset_pre_busrq got=%b exp=0", busrq_n); end
        busak_n = 1'b0;
        tick();
        checks++; if (dma_gnt !== 1'b1) begin errors++; $display("FAIL areset_pre_gnt got=%b exp=1", dma_gnt); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL areset_dma_gnt got=%b exp=0", dma_gnt); end
        checks++; if (busrq_n !== 1'b1) begin errors++; $display("FAIL areset_busrq_n got=%b exp=1", busrq_n); end
        checks++; if (bus_sel !== 1'b0) begin errors++; $display("FAIL areset_bus_sel got=%b exp=0", bus_sel); end
        checks++; if (timeout_flag !== 1'b0) begin errors++; $display("FAIL areset_timeout_flag got=%b exp=0", timeout_flag); end
        dma_req = 1'b0;
        busak_n = 1'b1;
        tick();
        reset_n = 1'b1;
        tick();
        checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL areset_after_gnt got=%b exp=0", dma_gnt); end
        checks++; if (busrq_n !== 1'b1) begin errors++; $display("FAIL areset_after_busrq got=%b exp=1", busrq_n); end
    endtask

    initial begin
        test_reset();
        test_dma_grant();
        test_dma_hold();
        test_release();
        test_wait();
        test_wait_defers_dma();
        test_wait4_defers_dma();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
